// File: rtl/sram_pipe_ctrl_if.sv
// Client/SRAM-side bus of the pipelined SRAM front-end controller.
// The controller takes the slave view; the client/SRAM environment takes the master view.
interface sram_pipe_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  memctrl_enable;
  logic                  memctrl_rw;
  logic [ADDR_WIDTH-1:0] memctrl_addr;
  logic [DATA_WIDTH-1:0] memctrl_write_data;
  logic [DATA_WIDTH-1:0] sram_out_data;
  logic                  dat_ready;
  logic [DATA_WIDTH-1:0] memctrl_out_data;
  logic                  sram_enable;
  logic                  sram_rw;
  logic [DATA_WIDTH-1:0] sram_write_data;
  logic [ADDR_WIDTH-1:0] sram_addr;

  modport slave (
    input  memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data, sram_out_data,
    output dat_ready, memctrl_out_data, sram_enable, sram_rw, sram_write_data, sram_addr
  );

  modport master (
    output memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data, sram_out_data,
    input  dat_ready, memctrl_out_data, sram_enable, sram_rw, sram_write_data, sram_addr
  );
endinterface

// File: rtl/sram_pipe_ctrl.sv
// Fully pipelined single-port SRAM front end: registered request issue, two-stage
// read-pending tracking, registered read return with a one-cycle dat_ready strobe.
module sram_pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  sram_pipe_ctrl_if.slave    bus
);

  logic                  sram_enable_q;
  logic                  sram_rw_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [DATA_WIDTH-1:0] sram_write_data_q;
  logic                  pend1_q;
  logic                  pend2_q;
  logic                  dat_ready_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sram_enable_q     <= 1'b0;
      sram_rw_q         <= 1'b0;
      sram_addr_q       <= '0;
      sram_write_data_q <= '0;
      pend1_q           <= 1'b0;
      pend2_q           <= 1'b0;
      dat_ready_q       <= 1'b0;
      out_data_q        <= '0;
    end else begin
      sram_enable_q <= bus.memctrl_enable;
      // Address and write data hold while idle so the SRAM port stays quiet.
      if (bus.memctrl_enable) begin
        sram_rw_q         <= bus.memctrl_rw;
        sram_addr_q       <= bus.memctrl_addr;
        sram_write_data_q <= bus.memctrl_write_data;
      end else begin
        sram_rw_q <= 1'b0;
      end
      pend1_q     <= bus.memctrl_enable & ~bus.memctrl_rw;
      pend2_q     <= pend1_q;
      dat_ready_q <= pend2_q;
      if (pend2_q) begin
        out_data_q <= bus.sram_out_data;
      end
    end
  end

  assign bus.sram_enable      = sram_enable_q;
  assign bus.sram_rw          = sram_rw_q;
  assign bus.sram_addr        = sram_addr_q;
  assign bus.sram_write_data  = sram_write_data_q;
  assign bus.dat_ready        = dat_ready_q;
  assign bus.memctrl_out_data = out_data_q;

endmodule

// File: tb/tb_sram_pipe_ctrl.sv
// Scoreboard bench for sram_pipe_ctrl: directed test-plan sequence followed by random
// traffic with occasional resets, checked against a word-array reference memory.
module tb_sram_pipe_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  logic clock;
  logic reset;

  sram_pipe_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_pipe_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM behavioural model (environment, not reference)
  logic [DW-1:0] sram_mem [2**AW];
  logic [DW-1:0] sram_rdata;
  assign bus.sram_out_data = sram_rdata;
  always @(posedge clock) begin
    if (bus.sram_enable === 1'b1) begin
      if (bus.sram_rw) sram_mem[bus.sram_addr] <= bus.sram_write_data;
      else             sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  // Reference: memory contents in issue order, expected read results with due cycle
  logic [DW-1:0] ref_mem [2**AW];
  exp_t          exp_q [$];
  int unsigned   cyc;
  int            checks;
  int            errors;
  logic [DW-1:0] exp_out;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
    end
  endtask

  task automatic issue(input bit rst_n, input bit en, input bit rw,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    exp_t e;
    @(negedge clock);
    #1;
    reset                  = rst_n;
    bus.memctrl_enable     = en;
    bus.memctrl_rw         = rw;
    bus.memctrl_addr       = addr;
    bus.memctrl_write_data = wd;
    if (rst_n && en) begin
      if (rw) begin
        ref_mem[addr] = wd;
      end else begin
        e.data = ref_mem[addr];
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: at the falling edge the request inputs are those sampled at the last rising edge
  always @(negedge clock) begin
    exp_t e;
    if (cyc > 0) begin
      if (!reset) begin
        exp_q.delete();
        exp_out  = '0;
        exp_addr = '0;
        exp_wd   = '0;
        check(bus.dat_ready == 1'b0, "reset_dat_ready", {31'b0, bus.dat_ready}, '0);
        check(bus.memctrl_out_data == '0, "reset_out_data", bus.memctrl_out_data, '0);
        check(bus.sram_enable == 1'b0, "reset_sram_enable", {31'b0, bus.sram_enable}, '0);
        check(bus.sram_rw == 1'b0, "reset_sram_rw", {31'b0, bus.sram_rw}, '0);
        check(bus.sram_addr == '0, "reset_sram_addr", {29'b0, bus.sram_addr}, '0);
        check(bus.sram_write_data == '0, "reset_sram_wdata", bus.sram_write_data, '0);
      end else begin
        if (bus.memctrl_enable) begin
          exp_addr = bus.memctrl_addr;
          exp_wd   = bus.memctrl_write_data;
        end
        check(bus.sram_enable == bus.memctrl_enable, "sram_enable",
              {31'b0, bus.sram_enable}, {31'b0, bus.memctrl_enable});
        check(bus.sram_rw == (bus.memctrl_enable & bus.memctrl_rw), "sram_rw",
              {31'b0, bus.sram_rw}, {31'b0, bus.memctrl_enable & bus.memctrl_rw});
        check(bus.sram_addr == exp_addr, "sram_addr", {29'b0, bus.sram_addr}, {29'b0, exp_addr});
        check(bus.sram_write_data == exp_wd, "sram_wdata", bus.sram_write_data, exp_wd);
        if (bus.dat_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_dat_ready", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check(cyc == e.cyc, "read_latency", cyc, e.cyc);
            check(bus.memctrl_out_data == e.data, "read_data", bus.memctrl_out_data, e.data);
            exp_out = e.data;
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          check(1'b0, "missing_dat_ready", 32'd0, 32'd1);
        end
        check(bus.memctrl_out_data == exp_out, "out_data_hold", bus.memctrl_out_data, exp_out);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    exp_out = '0;
    exp_addr = '0;
    exp_wd  = '0;
    sram_rdata = '0;
    for (int i = 0; i < 2**AW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_mem[1] = 32'h11111111; ref_mem[1] = 32'h11111111;
    sram_mem[2] = 32'h22222222; ref_mem[2] = 32'h22222222;

    // Reset held with a request present
    reset                  = 1'b0;
    bus.memctrl_enable     = 1'b1;
    bus.memctrl_rw         = 1'b0;
    bus.memctrl_addr       = 3'd5;
    bus.memctrl_write_data = 32'hA5A5A5A5;
    issue(1'b0, 1'b1, 1'b1, 3'd6, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 1'b0, 3'd1, 32'h0);
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);

    // Back-to-back reads
    issue(1'b1, 1'b1, 1'b0, 3'd1, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    // Read-after-write, same address
    issue(1'b1, 1'b1, 1'b1, 3'd3, 32'h56789ABC);
    issue(1'b1, 1'b1, 1'b0, 3'd3, 32'h0);
    // Reads separated by an idle gap
    issue(1'b1, 1'b1, 1'b0, 3'd1, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 3'd4, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 3'd4, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    // Read followed immediately by reset: discarded
    issue(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    // Top address write then reads of top and bottom address
    issue(1'b1, 1'b1, 1'b1, 3'd7, 32'hDEADBEEF);
    issue(1'b1, 1'b1, 1'b0, 3'd7, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            AW'($urandom), $urandom);
    end
    for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);

    @(negedge clock);
    #2;
    check(exp_q.size() == 0, "drain_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_pipe_ctrl.md
Name: sram_pipe_ctrl

Overview:
Pipelined front-end controller for a single-port synchronous SRAM, such as the message/hash memories of the SHA-256 accelerator. It accepts one read or write request per clock from a client and drives the SRAM port from registers. It captures SRAM read data and returns it to the client with a one-cycle data-valid strobe. The controller is fully pipelined: fixed latency, no backpressure, requests complete in issue order.

Parameters:
ADDR_WIDTH, 3, SRAM word-address width (depth = 2**ADDR_WIDTH).
DATA_WIDTH, 32, SRAM word width in bits.

Ports:
clock  input  1  single clock; all logic updates on rising edge.
reset  input  1  synchronous, active-low reset.
memctrl_enable  input  1  request valid this cycle.
memctrl_rw  input  1  request type: 1 = write, 0 = read.
memctrl_addr  input  ADDR_WIDTH  request word address.
memctrl_write_data  input  DATA_WIDTH  write data; ignored on reads.
sram_out_data  input  DATA_WIDTH  SRAM read_data; valid one cycle after the SRAM samples a read.
dat_ready  output  1  one-cycle strobe: memctrl_out_data carries a new read result.
memctrl_out_data  output  DATA_WIDTH  registered read result.
sram_enable  output  1  SRAM enable.
sram_rw  output  1  SRAM write strobe (1 = write).
sram_write_data  output  DATA_WIDTH  SRAM write data.
sram_addr  output  ADDR_WIDTH  SRAM address.

Behaviour:
- SRAM contract:
  - SRAM samples enable/write/address/write_data on a rising edge.
  - Write: commits the word at that edge.
  - Read: presents read_data after that edge, stable until the next SRAM access.
- Reset (reset==0 at a rising edge): all outputs, and the internal read-pending pipeline bits, clear to 0 (sram_enable=0, sram_rw=0, sram_addr=0, sram_write_data=0, dat_ready=0, memctrl_out_data=0). Reset overrides every other input, including a request in the same cycle.
- Reset mid-operation: in-flight reads are discarded and produce no dat_ready, even if reset is released next cycle.
- Stage 1, issue (edge E0):
  - sram_enable <= memctrl_enable.
  - When memctrl_enable=1: sram_rw <= memctrl_rw, sram_addr <= memctrl_addr, sram_write_data <= memctrl_write_data.
  - When memctrl_enable=0: sram_rw <= 0; sram_addr and sram_write_data hold their previous values.
  - pend1 <= memctrl_enable & ~memctrl_rw.
- Stage 2, SRAM access (edge E1): SRAM executes the registered request; pend2 <= pend1.
- Stage 3, return (edge E2): if pend2, then memctrl_out_data <= sram_out_data and dat_ready <= 1; else dat_ready <= 0 and memctrl_out_data holds.
- Read latency: a read accepted at edge E0 gives dat_ready=1 and valid data in the cycle after edge E2 (2 cycles after the SRAM request appears). dat_ready is high for exactly one cycle per read.
- Throughput: one request per cycle; back-to-back reads give back-to-back dat_ready pulses with data in request order.
- Writes never assert dat_ready and never alter memctrl_out_data.
- Read-after-write, same address, consecutive cycles: the read returns the new data, because the SRAM commits the write one edge before the read. No bypass logic is needed.
- Idle (memctrl_enable=0): no SRAM access; outputs quiesce after the pipeline drains.
- No address range checks; addresses wrap naturally at 2**ADDR_WIDTH.

Test Plan:
1. Reset low 1+ cycles with memctrl_enable=1 -> all outputs 0; dat_ready stays 0 for 3 cycles after release with no requests.
2. SRAM preloaded mem[1]=0x11111111, mem[2]=0x22222222. Reads addr 1 then addr 2 on consecutive cycles -> dat_ready high on two consecutive cycles, 2 cycles after the respective sram_enable, with memctrl_out_data 0x11111111 then 0x22222222.
3. Write addr 3 = 0x56789ABC, next cycle read addr 3 -> sram_rw=1 for one cycle, no dat_ready for the write, read returns 0x56789ABC.
4. Idle gap (memctrl_enable=0) between reads -> sram_enable=0 in the gap, dat_ready pulses separated by the gap, memctrl_out_data held between pulses.
5. Read addr 2 issued, reset asserted the next cycle -> no dat_ready for that read; memctrl_out_data=0.
6. Write addr 7 = 0xDEADBEEF, then read addr 7 and addr 0 (=0x00000000) -> 0xDEADBEEF then 0x00000000, confirming ordering and wrap-free top-address access.
